// File: rtl/id_stage.sv
// Instruction-decode stage: splits the instruction into fields, registers the
// decoded bundle behind a valid/ready handshake, and keeps a per-register
// pending-write scoreboard that stalls on RAW/WAW hazards.
module id_stage #(
    parameter int                OP_LEN   = 2,
    parameter int                ADDR_LEN = 5,
    parameter int                INST_LEN = OP_LEN + 3 * ADDR_LEN,
    parameter logic [OP_LEN-1:0] MEM_OP   = OP_LEN'(2'b11),
    parameter int                CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_LEN-1:0] inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_LEN-1:0]   alu_sig,
    output logic [ADDR_LEN-1:0] oper1,
    output logic [ADDR_LEN-1:0] oper2,
    output logic [ADDR_LEN-1:0] dest,
    output logic                mem_read,
    input  logic                wb_valid,
    input  logic [ADDR_LEN-1:0] wb_addr,
    output logic                hazard,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int NREG = 2 ** ADDR_LEN;

    // The field layout only works when the instruction is exactly op + 3 addresses.
    if (INST_LEN != OP_LEN + 3 * ADDR_LEN) begin : g_cfg_err
        $error("id_stage: INST_LEN must equal OP_LEN + 3*ADDR_LEN");
    end

    // Instruction fields
    logic [OP_LEN-1:0]   f_op;
    logic [ADDR_LEN-1:0] f_oper1;
    logic [ADDR_LEN-1:0] f_oper2;
    logic [ADDR_LEN-1:0] f_dest;

    assign f_op    = inst[INST_LEN-1:3*ADDR_LEN];
    assign f_oper1 = inst[3*ADDR_LEN-1:2*ADDR_LEN];
    assign f_oper2 = inst[2*ADDR_LEN-1:ADDR_LEN];
    assign f_dest  = inst[ADDR_LEN-1:0];

    // Registered state
    logic                out_valid_reg, out_valid_next;
    logic [OP_LEN-1:0]   alu_sig_reg,   alu_sig_next;
    logic [ADDR_LEN-1:0] oper1_reg,     oper1_next;
    logic [ADDR_LEN-1:0] oper2_reg,     oper2_next;
    logic [ADDR_LEN-1:0] dest_reg,      dest_next;
    logic                mem_read_reg,  mem_read_next;
    logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;
    logic [NREG-1:0]     sb_reg,        sb_next;

    // sb_eff is the scoreboard as seen this cycle, with the current writeback
    // already retired so a dependent instruction can issue in the same cycle.
    logic [NREG-1:0] sb_eff;
    logic            accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            assign sb_eff[gi] = sb_reg[gi] & ~(wb_valid && (wb_addr == ADDR_LEN'(gi)));
            if (gi == 0) begin : g_zero
                // Register 0 is hard-wired: it never becomes pending.
                assign sb_next[gi] = 1'b0;
            end else begin : g_reg
                // A same-cycle set from an accepted dest overrides the writeback clear.
                assign sb_next[gi] = sb_eff[gi] | (accept && (f_dest == ADDR_LEN'(gi)));
            end
        end
    endgenerate

    // Hazard detection and handshake
    logic haz_oper1, haz_oper2, haz_dest;

    assign haz_oper1 = (f_oper1 != '0) && sb_eff[f_oper1];
    assign haz_oper2 = (f_oper2 != '0) && sb_eff[f_oper2];
    assign haz_dest  = (f_dest  != '0) && sb_eff[f_dest];

    assign hazard   = in_valid && (haz_oper1 || haz_oper2 || haz_dest);
    assign in_ready = !hazard && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state for the output bundle and the stall counter
    always_comb begin
        out_valid_next = out_valid_reg;
        alu_sig_next   = alu_sig_reg;
        oper1_next     = oper1_reg;
        oper2_next     = oper2_reg;
        dest_next      = dest_reg;
        mem_read_next  = mem_read_reg;
        stall_cnt_next = stall_cnt_reg;

        if (accept) begin
            out_valid_next = 1'b1;
            alu_sig_next   = f_op;
            oper1_next     = f_oper1;
            oper2_next     = f_oper2;
            dest_next      = f_dest;
            mem_read_next  = (f_op == MEM_OP);
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (hazard && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_reg <= 1'b0;
            alu_sig_reg   <= '0;
            oper1_reg     <= '0;
            oper2_reg     <= '0;
            dest_reg      <= '0;
            mem_read_reg  <= 1'b0;
            stall_cnt_reg <= '0;
            sb_reg        <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            alu_sig_reg   <= alu_sig_next;
            oper1_reg     <= oper1_next;
            oper2_reg     <= oper2_next;
            dest_reg      <= dest_next;
            mem_read_reg  <= mem_read_next;
            stall_cnt_reg <= stall_cnt_next;
            sb_reg        <= sb_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign alu_sig   = alu_sig_reg;
    assign oper1     = oper1_reg;
    assign oper2     = oper2_reg;
    assign dest      = dest_reg;
    assign mem_read  = mem_read_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [16:0] inst;
    logic        out_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;

    logic        in_ready, out_valid, mem_read, hazard;
    logic [1:0]  alu_sig;
    logic [4:0]  oper1, oper2, dest;
    logic [7:0]  stall_cnt;

    logic        s_in_ready, s_out_valid, s_mem_read, s_hazard;
    logic [1:0]  s_alu_sig;
    logic [4:0]  s_oper1, s_oper2, s_dest;
    logic [1:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .alu_sig(alu_sig), .oper1(oper1),
        .oper2(oper2), .dest(dest), .mem_read(mem_read), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .hazard(hazard), .stall_cnt(stall_cnt)
    );

    // Same stimulus, narrow stall counter to exercise saturation.
    id_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready), .inst(inst),
        .out_valid(s_out_valid), .out_ready(out_ready), .alu_sig(s_alu_sig), .oper1(s_oper1),
        .oper2(s_oper2), .dest(s_dest), .mem_read(s_mem_read), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .hazard(s_hazard), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input int op, input int o1, input int o2, input int d);
        logic [1:0] a;
        logic [4:0] b, c, e;
        a = op[1:0]; b = o1[4:0]; c = o2[4:0]; e = d[4:0];
        return {a, b, c, e};
    endfunction

    task automatic step(input bit v, input logic [16:0] i, input bit ordy,
                        input bit wbv, input logic [4:0] wba);
        @(posedge clk);
        #1;
        in_valid = v; inst = i; out_ready = ordy; wb_valid = wbv; wb_addr = wba;
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]  pend;        // set of registers with an outstanding write
    bit [31:0]  eff;
    bit         m_valid;
    logic [1:0] m_op;
    logic [4:0] m_o1, m_o2, m_d;
    int         m_cnt, m_cnt_sat;
    bit         m_hz, m_rdy;
    int         i_o1, i_o2, i_d;

    always @(negedge clk) begin
        if (!rstn) begin
            pend = '0; m_valid = 0; m_op = 0; m_o1 = 0; m_o2 = 0; m_d = 0;
            m_cnt = 0; m_cnt_sat = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
        end else begin
            i_o1 = inst[14:10]; i_o2 = inst[9:5]; i_d = inst[4:0];
            eff = pend;
            if (wb_valid) eff[wb_addr] = 1'b0;
            m_hz  = in_valid && ((i_o1 != 0 && eff[i_o1]) || (i_o2 != 0 && eff[i_o2]) ||
                                 (i_d != 0 && eff[i_d]));
            m_rdy = !m_hz && (!m_valid || out_ready);

            chk("m_out_valid", out_valid, m_valid);
            chk("m_alu_sig",   alu_sig,   m_op);
            chk("m_oper1",     oper1,     m_o1);
            chk("m_oper2",     oper2,     m_o2);
            chk("m_dest",      dest,      m_d);
            chk("m_mem_read",  mem_read,  (m_op == 2'b11));
            chk("m_hazard",    hazard,    m_hz);
            chk("m_in_ready",  in_ready,  m_rdy);
            chk("m_stall_cnt", stall_cnt, m_cnt);
            chk("m_sat_cnt",   s_stall_cnt, m_cnt_sat);
            chk("m_sat_valid", s_out_valid, m_valid);

            // advance the model to what the next clock edge must produce
            pend = eff;
            if (in_valid && m_rdy) begin
                if (i_d != 0) pend[i_d] = 1'b1;
                m_valid = 1; m_op = inst[16:15];
                m_o1 = inst[14:10]; m_o2 = inst[9:5]; m_d = inst[4:0];
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (m_hz) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_sat < 3) m_cnt_sat++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0; in_valid = 0; inst = '0; out_ready = 1; wb_valid = 0; wb_addr = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_dest", dest, 0);
        #2 rstn = 1'b1;

        // decode of the reference instruction
        step(1, 17'b11_00001_00010_00011, 1, 0, 0);
        chk("dec_in_ready", in_ready, 1);
        step(1, mk(1, 4, 5, 6), 1, 0, 0);
        chk("dec_valid", out_valid, 1);
        chk("dec_alu", alu_sig, 3);
        chk("dec_oper1", oper1, 1);
        chk("dec_oper2", oper2, 2);
        chk("dec_dest", dest, 3);
        chk("dec_mem", mem_read, 1);
        chk("b2b_ready1", in_ready, 1);
        step(1, mk(0, 1, 2, 7), 1, 0, 0);
        chk("b2b_dest6", dest, 6);
        chk("b2b_ready2", in_ready, 1);
        step(0, '0, 1, 0, 0);
        chk("b2b_dest7", dest, 7);
        chk("b2b_mem0", mem_read, 0);

        // RAW on register 3, resolved by a bypassed writeback
        step(1, mk(1, 3, 0, 8), 1, 0, 0);
        chk("raw_hazard", hazard, 1);
        chk("raw_ready", in_ready, 0);
        chk("raw_cnt0", stall_cnt, 0);
        step(1, mk(1, 3, 0, 8), 1, 0, 0);
        chk("raw_cnt1", stall_cnt, 1);
        step(1, mk(1, 3, 0, 8), 1, 0, 0);
        chk("raw_cnt2", stall_cnt, 2);
        step(1, mk(1, 3, 0, 8), 1, 1, 3);
        chk("byp_hazard", hazard, 0);
        chk("byp_ready", in_ready, 1);
        step(0, '0, 1, 0, 0);
        chk("byp_oper1", oper1, 3);
        chk("byp_dest", dest, 8);

        // WAW on register 7; narrow counter saturates
        for (int k = 0; k < 4; k++) begin
            step(1, mk(2, 0, 0, 7), 1, 0, 0);
            chk("waw_hazard", hazard, 1);
        end
        step(0, '0, 1, 1, 7);
        chk("waw_cnt", stall_cnt, 7);
        chk("sat_cnt", s_stall_cnt, 3);

        // register 0 never stalls
        step(1, mk(1, 0, 0, 0), 1, 1, 0);
        chk("r0_hazard", hazard, 0);
        step(1, mk(1, 0, 0, 0), 1, 0, 0);
        chk("r0_ready", in_ready, 1);

        // backpressure
        step(1, mk(2, 1, 2, 9), 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, mk(0, 1, 2, 10), 0, 0, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_dest", dest, 9);
            chk("bp_ready", in_ready, 0);
        end
        step(1, mk(0, 1, 2, 10), 1, 0, 0);
        chk("bp_drain_ready", in_ready, 1);
        step(0, '0, 1, 0, 0);
        chk("bp_next_dest", dest, 10);
        step(0, '0, 1, 0, 0);
        chk("bp_empty", out_valid, 0);

        // simultaneous set and clear of register 5
        step(1, mk(0, 0, 0, 5), 1, 0, 0);
        step(1, mk(0, 0, 0, 5), 1, 1, 5);
        chk("sc_ready", in_ready, 1);
        step(1, mk(0, 5, 0, 11), 1, 0, 0);
        chk("sc_still_pending", hazard, 1);
        step(0, '0, 1, 1, 5);

        // asynchronous reset mid-stream
        step(1, mk(0, 0, 0, 12), 1, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("pre_rst_valid", out_valid, 1);
        #1;
        in_valid = 0; wb_valid = 0; rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_dest", dest, 0);
        chk("mid_rst_alu", alu_sig, 0);
        chk("mid_rst_cnt", stall_cnt, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        step(1, mk(0, 12, 6, 13), 1, 0, 0);
        chk("post_rst_hazard", hazard, 0);

        // randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0,
                 mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7)),
                 ($urandom % 4) != 0, ($urandom % 3) == 0, 5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised, registered instruction-decode stage for the small pipeline core.
- Splits each instruction into the op code and three register addresses (oper1, oper2, dest), and decodes the memory-read flag from the op code.
- Tracks outstanding destination writes in a scoreboard and stalls on RAW/WAW hazards.
- Sits between IF and EX, with valid/ready handshakes on both sides and a writeback port from WB.

Parameters:
- OP_LEN, 2, op code width (top bits of inst).
- ADDR_LEN, 5, register address width; register file has 2**ADDR_LEN entries.
- INST_LEN, OP_LEN+3*ADDR_LEN, instruction width; any other value is a configuration error (flag in simulation).
- MEM_OP, 2'b11, op code that asserts mem_read.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  IF presents a valid inst.
- in_ready  out  1  ID accepts inst this cycle.
- inst  in  INST_LEN  fields: op=[INST_LEN-1:3*ADDR_LEN], oper1=[3*ADDR_LEN-1:2*ADDR_LEN], oper2=[2*ADDR_LEN-1:ADDR_LEN], dest=[ADDR_LEN-1:0].
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EX consumes the bundle.
- alu_sig  out  OP_LEN  registered op code.
- oper1, oper2, dest  out  ADDR_LEN  registered addresses.
- mem_read  out  1  registered; 1 iff op==MEM_OP.
- wb_valid  in  1  WB retires a write this cycle.
- wb_addr  in  ADDR_LEN  register being written back.
- hazard  out  1  combinational; in_valid and the incoming inst conflicts with the scoreboard.
- stall_cnt  out  CNT_W  count of cycles with hazard=1, saturating.

Behaviour:
- Reset (rstn=0, asynchronous):
  - out_valid=0; alu_sig, oper1, oper2, dest, mem_read = 0; stall_cnt=0; scoreboard all 0.
  - Reset mid-operation discards the held bundle and all pending bits. No write-back is expected for those.
- Scoreboard:
  - One pending bit per register. Register 0 is never set and never causes a hazard.
  - sb_eff = scoreboard with bit wb_addr cleared when wb_valid. The same-cycle writeback is bypassed.
- Hazard:
  - hazard = in_valid & (sb_eff[oper1] | sb_eff[oper2] | sb_eff[dest]) for non-zero addresses.
  - RAW on the source registers; WAW on dest.
- Handshake:
  - in_ready = !hazard & (!out_valid | out_ready). in_ready may depend combinationally on out_ready.
  - accept = in_valid & in_ready.
- On accept:
  - Output registers load the decoded fields; out_valid<=1.
  - Scoreboard bit dest<=1 when dest!=0.
- When not accepting:
  - out_ready & out_valid → out_valid<=0.
  - Otherwise the outputs hold unchanged. Fields are stable while out_valid & !out_ready.
- Writeback:
  - wb_valid clears bit wb_addr at the edge.
  - If the same cycle's accept sets the same bit, the set wins.
  - wb_valid to a register that is not pending is ignored. wb_addr=0 is ignored.
- Latency and throughput:
  - One cycle from accept to out_valid.
  - Full throughput: 1 inst/cycle when hazard-free and out_ready=1.
- stall_cnt increments each cycle hazard=1 and saturates at 2**CNT_W-1.
- No combinational path from inst to the output fields. Outputs are registered only.

Test Plan:
- Reset: assert rstn=0 mid-stream with out_valid=1 and pending bits set → out_valid=0, all fields 0, stall_cnt=0 immediately. After release, a prior dest is no longer pending.
- Decode/throughput (defaults):
  - inst=17'b11_00001_00010_00011 → next cycle alu_sig=11, oper1=1, oper2=2, dest=3, mem_read=1.
  - Back-to-back independent insts with out_ready=1 → one bundle per cycle.
- RAW stall:
  - Issue dest=3, then an inst with oper1=3 → hazard=1, in_ready=0, stall_cnt counts up.
  - wb_valid=1, wb_addr=3 → accepted the same cycle via bypass.
- WAW plus register 0:
  - An inst with dest=3 while 3 is pending → stalls.
  - Insts using register 0 as source or dest never stall; the bit for 0 is never set.
- Backpressure: out_ready=0 for 4 cycles → fields and out_valid held, in_ready=0. out_ready=1 → drains, then the next inst is accepted.
- Simultaneous set/clear and saturation:
  - wb of register 5 in the same cycle as accepting dest=5 → 5 remains pending.
  - With CNT_W=2, a 6-cycle hazard → stall_cnt saturates at 3.
